// File: rtl/qtcore_scan_sequencer.sv
// qtcore_scan_sequencer
//   On-chip controller for the qtcore A1 scan chain and run control. It holds a
//   CHAIN_LEN-bit image buffer that the host fills and reads one byte at a time.
//   On command it resets the core, swaps the image with the core scan chain, or
//   runs the core until it halts or a cycle budget runs out.
//
// Ports
//   clk_in, rst_n_in       clock (shared with the core), async active-low reset
//   cmd_valid_in/ready_out command handshake; ready only while IDLE
//   cmd_op_in              0=XCHG, 1=RUN, 2=CORE_RESET, 3=reserved
//   cmd_budget_in          RUN cycle budget (0 = run no cycles)
//   img_wr_en_in/addr/wdata byte write into the image (IDLE only)
//   img_rdata_out          combinational byte read, 0 for out-of-range addresses
//   scan_out_in, halt_in   core scan output and halt flag
//   core_rst_out, scan_en_out, scan_data_out, proc_en_out   core control pins
//   busy_out, done_out     not-IDLE flag, one-cycle completion pulse
//   halted_out, timeout_out, bad_cmd_out, run_cycles_out   status of last command
module qtcore_scan_sequencer #(
  parameter int CHAIN_LEN  = 160,
  parameter int BYTE_AW    = 5,
  parameter int CNT_W      = 8,
  parameter int MIN_RUN    = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               cmd_valid_in,
  output logic               cmd_ready_out,
  input  logic [1:0]         cmd_op_in,
  input  logic [CNT_W-1:0]   cmd_budget_in,
  input  logic               img_wr_en_in,
  input  logic [BYTE_AW-1:0] img_addr_in,
  input  logic [7:0]         img_wdata_in,
  output logic [7:0]         img_rdata_out,
  input  logic               scan_out_in,
  input  logic               halt_in,
  output logic               core_rst_out,
  output logic               scan_en_out,
  output logic               scan_data_out,
  output logic               proc_en_out,
  output logic               busy_out,
  output logic               done_out,
  output logic               halted_out,
  output logic               timeout_out,
  output logic               bad_cmd_out,
  output logic [CNT_W-1:0]   run_cycles_out
);

  localparam int N_BYTES  = CHAIN_LEN / 8;
  localparam int STEP_MAX = (CHAIN_LEN > RST_CYCLES) ? CHAIN_LEN : RST_CYCLES;
  localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_SHIFT, S_RUN, S_DONE} state_t;

  state_t               state;
  logic [CHAIN_LEN-1:0] image;
  logic [STEP_W-1:0]    step;       // cycle index within RESET or SHIFT
  logic [CNT_W-1:0]     budget_q;

  // run_cycles_out doubles as the RUN cycle counter: before each RUN edge it
  // holds the number of completed cycles, after the exit edge the total.
  logic [CNT_W:0]   run_next;
  logic [CNT_W-1:0] run_sat;
  logic             budget_hit;
  logic             halt_ok;

  always_comb begin
    run_next   = {1'b0, run_cycles_out} + {{CNT_W{1'b0}}, 1'b1};
    run_sat    = run_next[CNT_W] ? {CNT_W{1'b1}} : run_next[CNT_W-1:0];
    budget_hit = (run_next == {1'b0, budget_q});
    halt_ok    = (run_cycles_out >= CNT_W'(MIN_RUN)) && halt_in;
  end

  // Byte-wise read with constant slices; unmatched (out-of-range) addresses read 0.
  always_comb begin
    img_rdata_out = '0;
    for (int k = 0; k < N_BYTES; k++) begin
      if (img_addr_in == BYTE_AW'(k)) img_rdata_out = image[8*k +: 8];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: the image buffer is reset on purpose: an aborted command must leave
    // no stale chain data visible to the host.
    if (!rst_n_in) begin
      state          <= S_IDLE;
      image          <= '0;
      step           <= '0;
      budget_q       <= '0;
      cmd_ready_out  <= 1'b1;
      core_rst_out   <= 1'b0;
      scan_en_out    <= 1'b0;
      scan_data_out  <= 1'b0;
      proc_en_out    <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      halted_out     <= 1'b0;
      timeout_out    <= 1'b0;
      bad_cmd_out    <= 1'b0;
      run_cycles_out <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (img_wr_en_in) begin
            for (int k = 0; k < N_BYTES; k++) begin
              if (img_addr_in == BYTE_AW'(k)) image[8*k +: 8] <= img_wdata_in;
            end
          end
          if (cmd_valid_in) begin
            cmd_ready_out <= 1'b0;
            busy_out      <= 1'b1;
            bad_cmd_out   <= 1'b0;
            step          <= '0;
            case (cmd_op_in)
              2'd0: begin
                state         <= S_SHIFT;
                scan_en_out   <= 1'b1;
                scan_data_out <= image[CHAIN_LEN-1];
              end
              2'd1: begin
                halted_out     <= 1'b0;
                run_cycles_out <= '0;
                budget_q       <= cmd_budget_in;
                if (cmd_budget_in == '0) begin
                  // Empty budget: finish without ever enabling the core.
                  state       <= S_DONE;
                  done_out    <= 1'b1;
                  timeout_out <= 1'b1;
                end else begin
                  state       <= S_RUN;
                  proc_en_out <= 1'b1;
                  timeout_out <= 1'b0;
                end
              end
              2'd2: begin
                state        <= S_RESET;
                core_rst_out <= 1'b1;
              end
              default: begin
                state       <= S_DONE;
                done_out    <= 1'b1;
                bad_cmd_out <= 1'b1;
              end
            endcase
          end
        end

        S_RESET: begin
          if (step == STEP_W'(RST_CYCLES - 1)) begin
            core_rst_out <= 1'b0;
            state        <= S_DONE;
            done_out     <= 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end

        S_SHIFT: begin
          // Image and core chain form one ring: MSB goes out, core bit comes in.
          image         <= {image[CHAIN_LEN-2:0], scan_out_in};
          scan_data_out <= image[CHAIN_LEN-2];
          if (step == STEP_W'(CHAIN_LEN - 1)) begin
            scan_en_out   <= 1'b0;
            scan_data_out <= 1'b0;
            state         <= S_DONE;
            done_out      <= 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end

        S_RUN: begin
          run_cycles_out <= run_sat;
          // Halt wins over budget expiry; early halts are ignored as stale.
          if (halt_ok || budget_hit) begin
            halted_out  <= halt_ok;
            timeout_out <= !halt_ok;
            proc_en_out <= 1'b0;
            state       <= S_DONE;
            done_out    <= 1'b1;
          end
        end

        S_DONE: begin
          state         <= S_IDLE;
          cmd_ready_out <= 1'b1;
          busy_out      <= 1'b0;
        end

        default: begin
          state         <= S_IDLE;
          cmd_ready_out <= 1'b1;
          busy_out      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qtcore_scan_sequencer.sv
// Scoreboard bench for qtcore_scan_sequencer. A behavioural scan chain stands
// in for the core; halt_in is driven directly. Commands push their expected
// completion (latency, status flags) into a queue that a monitor pops on done.
module tb_qtcore_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_budget = 8'd0;
  logic       img_wr_en = 1'b0;
  logic [4:0] img_addr = 5'd0;
  logic [7:0] img_wdata = 8'd0;
  logic [7:0] img_rdata;
  logic       scan_out;
  logic       halt = 1'b0;
  logic       core_rst, scan_en, scan_data, proc_en;
  logic       busy, done, halted, timeout, bad_cmd;
  logic [7:0] run_cycles;

  qtcore_scan_sequencer dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
    .cmd_op_in(cmd_op), .cmd_budget_in(cmd_budget),
    .img_wr_en_in(img_wr_en), .img_addr_in(img_addr),
    .img_wdata_in(img_wdata), .img_rdata_out(img_rdata),
    .scan_out_in(scan_out), .halt_in(halt),
    .core_rst_out(core_rst), .scan_en_out(scan_en),
    .scan_data_out(scan_data), .proc_en_out(proc_en),
    .busy_out(busy), .done_out(done), .halted_out(halted),
    .timeout_out(timeout), .bad_cmd_out(bad_cmd),
    .run_cycles_out(run_cycles)
  );

  always #5 clk = ~clk;

  // Core scan chain model: shifts in scan_data while scan_en, MSB is scan_out.
  logic [159:0] chain = '0;
  logic         chain_load = 1'b0;
  logic [159:0] chain_load_val = '0;
  assign scan_out = chain[159];
  always @(posedge clk) begin
    if (chain_load)   chain <= chain_load_val;
    else if (scan_en) chain <= {chain[158:0], scan_data};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin activity counters, sampled mid-cycle.
  int n_rst = 0, n_scan = 0, n_proc = 0, n_ovl = 0;
  always @(negedge clk) begin
    if (core_rst) n_rst <= n_rst + 1;
    if (scan_en)  n_scan <= n_scan + 1;
    if (proc_en)  n_proc <= n_proc + 1;
    if ((scan_en && proc_en) || (core_rst && (scan_en || proc_en))) n_ovl <= n_ovl + 1;
  end

  int n_pass = 0, n_total = 0;
  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  typedef struct {
    string      tag;
    int         acc;
    int         lat;
    logic       h, t, b;
    logic [7:0] rc;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        mon_e = sb_q.pop_front();
        check({mon_e.tag, "_latency"}, 160'(cyc - mon_e.acc), 160'(mon_e.lat));
        check({mon_e.tag, "_status"}, {halted, timeout, bad_cmd, run_cycles},
              {mon_e.h, mon_e.t, mon_e.b, mon_e.rc});
      end
    end
  end

  task automatic issue(input string tag, input logic [1:0] op, input logic [7:0] bud,
                       input int lat, input logic h, input logic t, input logic b,
                       input logic [7:0] rc);
    exp_t e;
    @(negedge clk);
    if (!cmd_ready) check({tag, "_ready"}, 0, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_budget = bud;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e.tag = tag; e.acc = cyc; e.lat = lat; e.h = h; e.t = t; e.b = b; e.rc = rc;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    img_wr_en = 1'b1; img_addr = a; img_wdata = d;
    @(posedge clk); #1;
    img_wr_en = 1'b0;
  endtask

  task automatic read_image(output logic [159:0] v);
    for (int k = 0; k < 20; k++) begin
      img_addr = 5'(k);
      #1;
      v[8*k +: 8] = img_rdata;
    end
  endtask

  task automatic read_byte(input logic [4:0] a, output logic [7:0] d);
    img_addr = a;
    #1;
    d = img_rdata;
  endtask

  localparam logic [159:0] IMG_PAT  = 160'h0123456789ABCDEFFEDCBA987654321013579BDF;
  localparam logic [159:0] CORE_PAT = {5{32'hDEADBEEF}};

  initial begin
    logic [159:0] v;
    logic [7:0]   d;
    int s_rst, s_scan, s_proc;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready_busy", {cmd_ready, busy, done}, 3'b100);
    check("reset_pins", {core_rst, scan_en, scan_data, proc_en}, 4'b0000);
    check("reset_status", {halted, timeout, bad_cmd, run_cycles}, 11'd0);
    read_image(v);
    check("reset_image", v, '0);

    // Fill the image byte-wise and read it back, plus out-of-range reads.
    for (int k = 0; k < 20; k++) begin
      v = IMG_PAT;
      write_byte(5'(k), v[8*k +: 8]);
    end
    @(negedge clk);
    read_image(v);
    check("image_readback", v, IMG_PAT);
    read_byte(5'd20, d);
    check("read_addr20", d, 8'h00);
    read_byte(5'd31, d);
    check("read_addr31", d, 8'h00);

    // Preload the core chain.
    @(negedge clk);
    chain_load = 1'b1; chain_load_val = CORE_PAT;
    @(posedge clk); #1;
    chain_load = 1'b0;

    // CORE_RESET: two reset cycles, done two edges after acceptance.
    s_rst = n_rst;
    issue("core_reset", 2'd2, 8'd0, 2, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_done("core_reset");
    check("core_rst_cycles", 160'(n_rst - s_rst), 160'd2);

    // XCHG with a dropped image write during the shift.
    s_scan = n_scan;
    issue("xchg1", 2'd0, 8'd0, 160, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (10) @(negedge clk);
    write_byte(5'd0, 8'h77);
    wait_done("xchg1");
    @(negedge clk);
    check("scan_en_cycles", 160'(n_scan - s_scan), 160'd160);
    read_image(v);
    check("xchg1_image", v, CORE_PAT);
    check("xchg1_chain", chain, IMG_PAT);

    // RUN cases: budget expiry, halt at the mask boundary, priority, masked halt.
    halt = 1'b0;
    s_proc = n_proc;
    issue("run_b8", 2'd1, 8'd8, 8, 1'b0, 1'b1, 1'b0, 8'd8);
    wait_done("run_b8");
    check("run_b8_proc_cycles", 160'(n_proc - s_proc), 160'd8);

    halt = 1'b1;
    issue("run_b8_halt", 2'd1, 8'd8, 5, 1'b1, 1'b0, 1'b0, 8'd5);
    wait_done("run_b8_halt");
    issue("run_b5_halt", 2'd1, 8'd5, 5, 1'b1, 1'b0, 1'b0, 8'd5);
    wait_done("run_b5_halt");
    issue("run_b3_halt", 2'd1, 8'd3, 3, 1'b0, 1'b1, 1'b0, 8'd3);
    wait_done("run_b3_halt");

    s_proc = n_proc;
    issue("run_b0", 2'd1, 8'd0, 0, 1'b0, 1'b1, 1'b0, 8'd0);
    wait_done("run_b0");
    check("run_b0_proc_cycles", 160'(n_proc - s_proc), 160'd0);

    halt = 1'b0;
    issue("run_b255", 2'd1, 8'd255, 255, 1'b0, 1'b1, 1'b0, 8'd255);
    wait_done("run_b255");

    // Reserved op: immediate done, bad_cmd set, RUN status held, no pin activity.
    s_rst = n_rst; s_scan = n_scan; s_proc = n_proc;
    issue("bad_op", 2'd3, 8'd0, 0, 1'b0, 1'b1, 1'b1, 8'd255);
    wait_done("bad_op");
    @(negedge clk);
    check("bad_op_pins", 160'((n_rst - s_rst) + (n_scan - s_scan) + (n_proc - s_proc)), 160'd0);

    // Second XCHG swaps back and clears bad_cmd.
    issue("xchg2", 2'd0, 8'd0, 160, 1'b0, 1'b1, 1'b0, 8'd255);
    wait_done("xchg2");
    @(negedge clk);
    read_image(v);
    check("xchg2_image", v, IMG_PAT);
    check("xchg2_chain", chain, CORE_PAT);

    // Abort mid-shift with reset.
    issue("xchg_abort", 2'd0, 8'd0, 160, 1'b0, 1'b1, 1'b0, 8'd255);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("abort_outputs", {cmd_ready, busy, done, core_rst, scan_en, scan_data, proc_en},
          7'b1000000);
    check("abort_status", {halted, timeout, bad_cmd, run_cycles}, 11'd0);
    read_image(v);
    check("abort_image", v, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("pin_overlap", 160'(n_ovl), 160'd0);
    check("scoreboard_empty", 160'(sb_q.size()), 160'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/qtcore_scan_sequencer.md
Name: qtcore_scan_sequencer

Overview:
On-chip controller that sequences the qtcore A1 scan chain and run control, replacing bench-driven bit-banging. It holds a CHAIN_LEN-bit image buffer that a host fills and reads byte-wise. On command it can reset the core, exchange the image with the core scan chain, or run the core until halt or until a cycle budget expires. It sits between the host/test interface and the core's rst/scan_enable/scan_in/proc_en pins, and shares the core clock.

Parameters:
CHAIN_LEN, 160, scan chain length in bits (24 state/PC/IR/ACC + 15x8 memory/IO + 16 key); must be a multiple of 8
BYTE_AW, 5, image byte address width (ceil(log2(CHAIN_LEN/8)))
CNT_W, 8, width of the run cycle budget and cycle counter
MIN_RUN, 4, run cycles before halt_in is honoured (stale-halt mask)
RST_CYCLES, 2, cycles core_rst_out is held high

Ports:
clk_in  in  1  clock, shared with core
rst_n_in  in  1  asynchronous active-low reset
cmd_valid_in  in  1  command request
cmd_ready_out  out  1  high in IDLE only
cmd_op_in  in  2  0=XCHG, 1=RUN, 2=CORE_RESET, 3=reserved
cmd_budget_in  in  CNT_W  max run cycles (RUN only); 0 means no cycles
img_wr_en_in  in  1  byte write to image (ignored unless IDLE)
img_addr_in  in  BYTE_AW  byte index; byte k = image[8k+7:8k]
img_wdata_in  in  8  write data
img_rdata_out  out  8  combinational read of byte img_addr_in; 0 if addr out of range
scan_out_in  in  1  core scan_out
halt_in  in  1  core halt
core_rst_out  out  1  core reset, active high
scan_en_out  out  1  core scan enable, active high
scan_data_out  out  1  core scan_in
proc_en_out  out  1  core processor enable, active high
busy_out  out  1  state != IDLE
done_out  out  1  one-cycle pulse on command completion
halted_out  out  1  last RUN ended on halt
timeout_out  out  1  last RUN ended on budget
bad_cmd_out  out  1  last command was reserved op
run_cycles_out  out  CNT_W  cycles proc_en_out was high in last RUN

Behaviour:
- Reset (async, rst_n_in low): state IDLE, image all 0, all outputs 0 except cmd_ready_out=1; counters 0.
- States: IDLE, RESET, SHIFT, RUN, DONE.
- IDLE: accepts command when cmd_valid_in && cmd_ready_out on a rising edge. Op 0 -> SHIFT, op 1 -> RUN (clears status flags and run_cycles), op 2 -> RESET, op 3 -> DONE with bad_cmd_out=1. Any accepted valid op clears bad_cmd_out. Image writes in IDLE take effect next edge; writes in other states dropped.
- RESET: core_rst_out=1 for exactly RST_CYCLES cycles, then DONE.
- SHIFT: exactly CHAIN_LEN cycles with scan_en_out=1, scan_data_out=image[CHAIN_LEN-1] (registered, valid during the cycle). Each edge: image <= {image[CHAIN_LEN-2:0], scan_out_in} (pre-edge value sampled). After CHAIN_LEN cycles image holds old core chain, core holds old image; scan_en_out drops with the transition to DONE.
- RUN: proc_en_out=1; counter increments each cycle. Exit to DONE at edge where (count>=MIN_RUN && halt_in) -> halted_out=1, or count+1==budget -> timeout_out=1; halt takes priority if both. Budget 0 -> DONE immediately, proc_en_out never asserted, timeout_out=1. run_cycles_out = cycles proc_en_out was high. Counter saturates at 2^CNT_W-1.
- DONE: one cycle, done_out=1, all core controls 0, then IDLE. Status flags hold until next accepted command.
- scan_en_out and proc_en_out never high simultaneously; core_rst_out never high with either.
- rst_n_in mid-command: immediate abort, all outputs to reset values, image cleared; partial core chain state undefined.

Test Plan:
- Write bytes 0..19 (state=001, PC=1, IR=E0, ACC=01, MEM0..4=E0..E4, IO=F0, key bytes), CORE_RESET then XCHG -> done after 1+2 / 160 cycles, core PC=1, ACC=01, led=1111000, image reads all zero.
- RUN budget 8 after test 1 -> ACC=0x0B, timeout_out=1, run_cycles_out=8; XCHG -> image PC=5, IR=E4, MEM0..4 unchanged.
- Load halt program (MEM0=0D, MEM1=F2, ..., correct key), RUN budget 255 -> halted_out=1, run_cycles_out<255; XCHG -> MEM12=01, MEM13=00.
- halt_in tied high, RUN budget 8 -> halted_out at count 4 exactly, run_cycles_out=5; budget 0 -> timeout_out=1, proc_en_out never high.
- cmd_op 3 -> done_out next cycle, bad_cmd_out=1, no core pin toggles; image write during SHIFT dropped.
- Assert rst_n_in at SHIFT cycle 50 -> scan_en_out low same cycle, busy_out=0, image reads 0.
